// File: rtl/lvt_port_initiator_if.sv
// rtl/lvt_port_initiator_if.sv - write/read request, read response and memory-port bundle
// master modport is the requesting/memory side; slave modport is the initiator itself.
interface lvt_port_initiator_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic              wr0_valid;
  logic              wr0_ready;
  logic [ADDR_W-1:0] wr0_addr;
  logic [DATA_W-1:0] wr0_data;
  logic              wr1_valid;
  logic              wr1_ready;
  logic [ADDR_W-1:0] wr1_addr;
  logic [DATA_W-1:0] wr1_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ADDR_W-1:0] rsp_addr;
  logic [DATA_W-1:0] rsp_data;
  logic              mem_wr0_en;
  logic [ADDR_W-1:0] mem_wr0_addr;
  logic [DATA_W-1:0] mem_wr0_data;
  logic              mem_wr1_en;
  logic [ADDR_W-1:0] mem_wr1_addr;
  logic [DATA_W-1:0] mem_wr1_data;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;

  modport master (
    output wr0_valid, wr0_addr, wr0_data,
    input  wr0_ready,
    output wr1_valid, wr1_addr, wr1_data,
    input  wr1_ready,
    output rd_valid, rd_addr,
    input  rd_ready,
    input  rsp_valid, rsp_addr, rsp_data,
    output rsp_ready,
    input  mem_wr0_en, mem_wr0_addr, mem_wr0_data,
    input  mem_wr1_en, mem_wr1_addr, mem_wr1_data,
    input  mem_rd_en, mem_rd_addr,
    output mem_rd_data
  );

  modport slave (
    input  wr0_valid, wr0_addr, wr0_data,
    output wr0_ready,
    input  wr1_valid, wr1_addr, wr1_data,
    output wr1_ready,
    input  rd_valid, rd_addr,
    output rd_ready,
    output rsp_valid, rsp_addr, rsp_data,
    input  rsp_ready,
    output mem_wr0_en, mem_wr0_addr, mem_wr0_data,
    output mem_wr1_en, mem_wr1_addr, mem_wr1_data,
    output mem_rd_en, mem_rd_addr,
    input  mem_rd_data
  );
endinterface

// File: rtl/lvt_port_initiator.sv
// rtl/lvt_port_initiator.sv - two-write/one-read port initiator with 2-entry response FIFO
// Optional collision/hazard statistics counters under macro LVT_INIT_STATS_EN.
module lvt_port_initiator #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input logic                clk,
  input logic                rst,
  lvt_port_initiator_if.slave bus
`ifdef LVT_INIT_STATS_EN
  ,
  output logic [15:0]        collide_cnt,
  output logic [15:0]        hazard_cnt
`endif
);

  logic              wr0_rdy;
  logic              wr1_rdy;
  logic              wr0_fire;
  logic              wr1_fire;
  logic              raw_hazard;
  logic              credit_full;
  logic              rd_rdy;
  logic              rd_fire;
  logic              inflight;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [1:0]        count;
  logic [1:0]        occupancy;
  logic              wr_ptr;
  logic              rd_ptr;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] fifo_addr [2];
  logic [DATA_W-1:0] fifo_data [2];

  // Channel 0 wins a same-address collision; channel 1 retries next cycle.
  assign wr0_rdy  = !rst;
  assign wr1_rdy  = !rst && !(bus.wr0_valid && (bus.wr0_addr == bus.wr1_addr));
  assign wr0_fire = bus.wr0_valid && wr0_rdy;
  assign wr1_fire = bus.wr1_valid && wr1_rdy;

  assign raw_hazard = (wr0_fire && (bus.wr0_addr == bus.rd_addr)) ||
                      (wr1_fire && (bus.wr1_addr == bus.rd_addr));

  // Outstanding reads are limited to FIFO depth; a pop this cycle earns no credit.
  assign occupancy   = count + {1'b0, inflight};
  assign credit_full = occupancy[1];
  assign rd_rdy      = !rst && !raw_hazard && !credit_full;
  assign rd_fire     = bus.rd_valid && rd_rdy;

  assign bus.wr0_ready    = wr0_rdy;
  assign bus.wr1_ready    = wr1_rdy;
  assign bus.rd_ready     = rd_rdy;
  assign bus.mem_wr0_en   = wr0_fire;
  assign bus.mem_wr0_addr = bus.wr0_addr;
  assign bus.mem_wr0_data = bus.wr0_data;
  assign bus.mem_wr1_en   = wr1_fire;
  assign bus.mem_wr1_addr = bus.wr1_addr;
  assign bus.mem_wr1_data = bus.wr1_data;
  assign bus.mem_rd_en    = rd_fire;
  assign bus.mem_rd_addr  = bus.rd_addr;

  assign push = inflight;
  assign pop  = (count != 2'd0) && bus.rsp_ready;

  assign bus.rsp_valid = (count != 2'd0);
  assign bus.rsp_addr  = fifo_addr[rd_ptr];
  assign bus.rsp_data  = fifo_data[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight  <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      inflight <= rd_fire;
      if (rd_fire) begin
        rd_addr_q <= bus.rd_addr;
      end
    end
  end

  // Storage is cleared so the head entry reads as zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count        <= 2'd0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      fifo_addr[0] <= '0;
      fifo_addr[1] <= '0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
    end else begin
      if (push) begin
        fifo_addr[wr_ptr] <= rd_addr_q;
        fifo_data[wr_ptr] <= bus.mem_rd_data;
        wr_ptr            <= !wr_ptr;
      end
      if (pop) begin
        rd_ptr <= !rd_ptr;
      end
      if (push && !pop) begin
        count <= count + 2'd1;
      end else if (pop && !push) begin
        count <= count - 2'd1;
      end
    end
  end

`ifdef LVT_INIT_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      collide_cnt <= 16'd0;
      hazard_cnt  <= 16'd0;
    end else begin
      if (bus.wr1_valid && !wr1_rdy && (collide_cnt != 16'hFFFF)) begin
        collide_cnt <= collide_cnt + 16'd1;
      end
      if (bus.rd_valid && raw_hazard && (hazard_cnt != 16'hFFFF)) begin
        hazard_cnt <= hazard_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lvt_port_initiator.sv
// tb/tb_lvt_port_initiator.sv - directed self-checking bench for lvt_port_initiator
// Stats checks run only when LVT_INIT_STATS_EN is defined.
module tb_lvt_port_initiator;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  logic [31:0] mem [0:127];

  lvt_port_initiator_if #(.ADDR_W(7), .DATA_W(32)) bus ();

`ifdef LVT_INIT_STATS_EN
  logic [15:0] collide_cnt;
  logic [15:0] hazard_cnt;
`endif

  lvt_port_initiator #(.ADDR_W(7), .DATA_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef LVT_INIT_STATS_EN
    ,
    .collide_cnt(collide_cnt),
    .hazard_cnt(hazard_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: synchronous writes, one-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_wr0_en) mem[bus.mem_wr0_addr] <= bus.mem_wr0_data;
    if (bus.mem_wr1_en) mem[bus.mem_wr1_addr] <= bus.mem_wr1_data;
    if (bus.mem_rd_en)  bus.mem_rd_data <= mem[bus.mem_rd_addr];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr0_valid = 1'b0;
    bus.wr1_valid = 1'b0;
    bus.rd_valid  = 1'b0;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic do_read(input logic [6:0] a, input logic [31:0] exp_d);
    int n;
    bus.rd_valid = 1'b1;
    bus.rd_addr  = a;
    #1;
    n = 0;
    while (!bus.rd_ready && n < 20) begin
      tick();
      n++;
    end
    chk("rd_accept", bus.rd_ready, 1);
    tick();
    bus.rd_valid = 1'b0;
    #1;
    chk("rsp_lat1", bus.rsp_valid, 0);
    tick();
    chk("rsp_lat2", bus.rsp_valid, 1);
    chk("rsp_addr", bus.rsp_addr, a);
    chk("rsp_data", bus.rsp_data, exp_d);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    #1;
    chk("rsp_drained", bus.rsp_valid, 0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    idle();
    bus.wr0_addr = '0; bus.wr0_data = '0;
    bus.wr1_addr = '0; bus.wr1_data = '0;
    bus.rd_addr  = '0;
    tick();

    // Reset: everything held low even with valids asserted
    bus.wr0_valid = 1'b1; bus.wr1_valid = 1'b1; bus.rd_valid = 1'b1;
    bus.wr1_addr = 7'h01; bus.rd_addr = 7'h02;
    #1;
    chk("rst_wr0_ready", bus.wr0_ready, 0);
    chk("rst_wr1_ready", bus.wr1_ready, 0);
    chk("rst_rd_ready", bus.rd_ready, 0);
    chk("rst_mem_wr0_en", bus.mem_wr0_en, 0);
    chk("rst_mem_wr1_en", bus.mem_wr1_en, 0);
    chk("rst_mem_rd_en", bus.mem_rd_en, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    idle();
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_wr0_ready", bus.wr0_ready, 1);
    chk("post_rst_rsp_valid", bus.rsp_valid, 0);
    chk("post_rst_rsp_addr", bus.rsp_addr, 0);
    chk("post_rst_rsp_data", bus.rsp_data, 0);
    tick();

    // Write collision at 0x05
    bus.wr0_valid = 1'b1; bus.wr0_addr = 7'h05; bus.wr0_data = 32'hAAAA;
    bus.wr1_valid = 1'b1; bus.wr1_addr = 7'h05; bus.wr1_data = 32'hBBBB;
    #1;
    chk("col_mem_wr0_en", bus.mem_wr0_en, 1);
    chk("col_mem_wr0_data", bus.mem_wr0_data, 32'hAAAA);
    chk("col_wr1_ready", bus.wr1_ready, 0);
    chk("col_mem_wr1_en", bus.mem_wr1_en, 0);
    tick();
    bus.wr0_valid = 1'b0;
    #1;
    chk("col2_wr1_ready", bus.wr1_ready, 1);
    chk("col2_mem_wr1_en", bus.mem_wr1_en, 1);
    chk("col2_mem_wr1_addr", bus.mem_wr1_addr, 7'h05);
    tick();
    idle();
    do_read(7'h05, 32'hBBBB);

    // Different addresses on both channels: no collision
    bus.wr0_valid = 1'b1; bus.wr0_addr = 7'h06; bus.wr0_data = 32'h6;
    bus.wr1_valid = 1'b1; bus.wr1_addr = 7'h07; bus.wr1_data = 32'h7;
    #1;
    chk("nocol_wr1_ready", bus.wr1_ready, 1);
    tick();
    idle();

    // RAW hazard on channel 0
    bus.wr0_valid = 1'b1; bus.wr0_addr = 7'h12; bus.wr0_data = 32'h1234;
    bus.rd_valid = 1'b1; bus.rd_addr = 7'h12;
    #1;
    chk("raw_rd_ready", bus.rd_ready, 0);
    chk("raw_mem_rd_en", bus.mem_rd_en, 0);
    chk("raw_mem_wr0_en", bus.mem_wr0_en, 1);
    tick();
    bus.wr0_valid = 1'b0;
    do_read(7'h12, 32'h1234);

    // RAW hazard on channel 1, and no false hazard on another address
    bus.wr1_valid = 1'b1; bus.wr1_addr = 7'h20; bus.wr1_data = 32'h2020;
    bus.rd_valid = 1'b1; bus.rd_addr = 7'h20;
    #1;
    chk("raw1_rd_ready", bus.rd_ready, 0);
    bus.rd_addr = 7'h21;
    #1;
    chk("noraw_rd_ready", bus.rd_ready, 1);
    bus.rd_valid = 1'b0;
    tick();
    idle();

    // Backpressure with three reads
    bus.wr0_valid = 1'b1; bus.wr0_addr = 7'h01; bus.wr0_data = 32'h111;
    bus.wr1_valid = 1'b1; bus.wr1_addr = 7'h02; bus.wr1_data = 32'h222;
    tick();
    bus.wr1_valid = 1'b0;
    bus.wr0_addr = 7'h03; bus.wr0_data = 32'h333;
    tick();
    idle();
    bus.rd_valid = 1'b1; bus.rd_addr = 7'h01;
    #1;
    chk("bp_rd1_ready", bus.rd_ready, 1);
    tick();
    bus.rd_addr = 7'h02;
    #1;
    chk("bp_rd2_ready", bus.rd_ready, 1);
    tick();
    bus.rd_addr = 7'h03;
    #1;
    chk("bp_rd3_stall", bus.rd_ready, 0);
    chk("bp_rd3_mem_rd_en", bus.mem_rd_en, 0);
    tick();
    chk("bp_rd3_stall2", bus.rd_ready, 0);
    chk("bp_head_valid", bus.rsp_valid, 1);
    chk("bp_head_addr", bus.rsp_addr, 7'h01);
    chk("bp_head_data", bus.rsp_data, 32'h111);
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_pop_no_credit", bus.rd_ready, 0);
    tick();
    chk("bp_second_addr", bus.rsp_addr, 7'h02);
    chk("bp_second_data", bus.rsp_data, 32'h222);
    chk("bp_rd3_accept", bus.rd_ready, 1);
    tick();
    bus.rd_valid = 1'b0;
    #1;
    chk("bp_empty", bus.rsp_valid, 0);
    tick();
    chk("bp_third_valid", bus.rsp_valid, 1);
    chk("bp_third_addr", bus.rsp_addr, 7'h03);
    chk("bp_third_data", bus.rsp_data, 32'h333);
    tick();
    chk("bp_drained", bus.rsp_valid, 0);
    idle();

    // Reset with one buffered response and one read in flight
    bus.rd_valid = 1'b1; bus.rd_addr = 7'h12;
    tick();
    bus.rd_addr = 7'h05;
    tick();
    bus.rd_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("after_rst_rsp_valid", bus.rsp_valid, 0);
    end
    chk("after_rst_rsp_addr", bus.rsp_addr, 0);
    chk("after_rst_rsp_data", bus.rsp_data, 0);
    do_read(7'h05, 32'hBBBB);

`ifdef LVT_INIT_STATS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("stats_rst_collide", collide_cnt, 0);
    chk("stats_rst_hazard", hazard_cnt, 0);
    bus.wr0_valid = 1'b1; bus.wr0_addr = 7'h30; bus.wr0_data = 32'h30;
    bus.rd_valid = 1'b1; bus.rd_addr = 7'h30;
    tick();
    idle();
    chk("stats_hazard_one", hazard_cnt, 1);
    bus.wr0_valid = 1'b1; bus.wr0_addr = 7'h07; bus.wr0_data = 32'h70;
    bus.wr1_valid = 1'b1; bus.wr1_addr = 7'h07; bus.wr1_data = 32'h71;
    for (int i = 0; i < 3; i++) tick();
    chk("stats_collide_three", collide_cnt, 3);
    for (int i = 0; i < 32'h10000 - 3; i++) tick();
    chk("stats_collide_sat", collide_cnt, 16'hFFFF);
    idle();
    rst = 1'b1;
    #1;
    chk("stats_collide_clear", collide_cnt, 0);
    tick();
    rst = 1'b0;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
